// File: rtl/cam_ctrl.sv
// cam_ctrl: command sequencer in front of cam_core.
// Runs LOOKUP / INSERT / DELETE / FLUSH as a search-then-write sequence on
// the CAM ports, keeps a valid bitmap for slot allocation and duplicate
// rejection, and sweeps the CAM clear after reset (the table has no reset).
// All outputs are registered: the combinational block computes the values
// for the next cycle and the state register holds the phase being shown.
// Optional: define CAM_CTRL_STATS_EN to add saturating lookup/hit/full counters.
module cam_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH:0]   occ_count,
  output logic                  init_done,
  output logic                  cam_we,
  output logic [ADDR_WIDTH-1:0] cam_addr,
  output logic [DATA_WIDTH-1:0] cam_data,
  output logic                  cam_valid,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  lookup_hit
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_lookups,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_full
`endif
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  localparam logic [1:0] RS_OK       = 2'b00;
  localparam logic [1:0] RS_NOTFOUND = 2'b01;
  localparam logic [1:0] RS_DUP      = 2'b10;
  localparam logic [1:0] RS_FULL     = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_EVAL   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_RESP   = 3'd6
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH:0]     sweep_r, sweep_nxt_s;
  logic [DEPTH-1:0]        bitmap_r, bitmap_nxt_s;
  logic [1:0]              op_r, op_nxt_s;
  logic [DATA_WIDTH-1:0]   key_nxt_s;
  logic                    req_ready_nxt_s;
  logic                    rsp_valid_nxt_s;
  logic [1:0]              rsp_status_nxt_s;
  logic [ADDR_WIDTH-1:0]   rsp_addr_nxt_s;
  logic                    init_done_nxt_s;
  logic                    cam_we_nxt_s;
  logic [ADDR_WIDTH-1:0]   cam_addr_nxt_s;
  logic [DATA_WIDTH-1:0]   cam_data_nxt_s;
  logic                    cam_valid_nxt_s;

  // Lowest-index free slot in the bitmap (0 when the table is full).
  function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [DEPTH-1:0] bm);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!bm[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

  // Number of set bits; occupancy is always derived from the bitmap.
  function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] bm);
    logic [ADDR_WIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + (ADDR_WIDTH+1)'(bm[i]);
    end
    return cnt;
  endfunction

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_INIT;
      sweep_r     <= '0;
      bitmap_r    <= '0;
      op_r        <= 2'b00;
      lookup_data <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_status  <= 2'b00;
      rsp_addr    <= '0;
      occ_count   <= '0;
      init_done   <= 1'b0;
      cam_we      <= 1'b0;
      cam_addr    <= '0;
      cam_data    <= '0;
      cam_valid   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sweep_r     <= sweep_nxt_s;
      bitmap_r    <= bitmap_nxt_s;
      op_r        <= op_nxt_s;
      lookup_data <= key_nxt_s;
      req_ready   <= req_ready_nxt_s;
      rsp_valid   <= rsp_valid_nxt_s;
      rsp_status  <= rsp_status_nxt_s;
      rsp_addr    <= rsp_addr_nxt_s;
      occ_count   <= popcount(bitmap_nxt_s);
      init_done   <= init_done_nxt_s;
      cam_we      <= cam_we_nxt_s;
      cam_addr    <= cam_addr_nxt_s;
      cam_data    <= cam_data_nxt_s;
      cam_valid   <= cam_valid_nxt_s;
    end
  end

  // Next state and next-cycle output values.
  always_comb begin
    state_nxt_s      = state_r;
    sweep_nxt_s      = sweep_r;
    bitmap_nxt_s     = bitmap_r;
    op_nxt_s         = op_r;
    key_nxt_s        = lookup_data;
    req_ready_nxt_s  = 1'b0;
    rsp_valid_nxt_s  = 1'b0;
    rsp_status_nxt_s = 2'b00;
    rsp_addr_nxt_s   = '0;
    init_done_nxt_s  = init_done;
    cam_we_nxt_s     = 1'b0;
    cam_addr_nxt_s   = '0;
    cam_data_nxt_s   = '0;
    cam_valid_nxt_s  = 1'b0;

    case (state_r)
      ST_INIT, ST_FLUSH: begin
        if (sweep_r == DEPTH_C) begin
          sweep_nxt_s = '0;
          if (state_r == ST_INIT) begin
            state_nxt_s     = ST_IDLE;
            init_done_nxt_s = 1'b1;
            req_ready_nxt_s = 1'b1;
          end else begin
            bitmap_nxt_s     = '0;
            state_nxt_s      = ST_RESP;
            rsp_valid_nxt_s  = 1'b1;
            rsp_status_nxt_s = RS_OK;
          end
        end else begin
          cam_we_nxt_s   = 1'b1;
          cam_addr_nxt_s = sweep_r[ADDR_WIDTH-1:0];
          sweep_nxt_s    = sweep_r + (ADDR_WIDTH+1)'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          op_nxt_s  = req_op;
          key_nxt_s = req_key;
          if (req_op == OP_FLUSH) begin
            // First invalidating write goes out with the accept.
            state_nxt_s    = ST_FLUSH;
            cam_we_nxt_s   = 1'b1;
            cam_addr_nxt_s = '0;
            sweep_nxt_s    = (ADDR_WIDTH+1)'(1);
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end
      ST_SEARCH: begin
        state_nxt_s = ST_EVAL;
      end
      ST_EVAL: begin
        case (op_r)
          OP_LOOKUP: begin
            state_nxt_s      = ST_RESP;
            rsp_valid_nxt_s  = 1'b1;
            rsp_status_nxt_s = lookup_hit ? RS_OK : RS_NOTFOUND;
            rsp_addr_nxt_s   = lookup_hit ? lookup_addr : '0;
          end
          OP_INSERT: begin
            if (lookup_hit) begin
              state_nxt_s      = ST_RESP;
              rsp_valid_nxt_s  = 1'b1;
              rsp_status_nxt_s = RS_DUP;
              rsp_addr_nxt_s   = lookup_addr;
            end else if (occ_count == DEPTH_C) begin
              state_nxt_s      = ST_RESP;
              rsp_valid_nxt_s  = 1'b1;
              rsp_status_nxt_s = RS_FULL;
            end else begin
              state_nxt_s     = ST_WRITE;
              cam_we_nxt_s    = 1'b1;
              cam_addr_nxt_s  = lowest_free(bitmap_r);
              cam_data_nxt_s  = lookup_data;
              cam_valid_nxt_s = 1'b1;
            end
          end
          OP_DELETE: begin
            if (lookup_hit) begin
              state_nxt_s    = ST_WRITE;
              cam_we_nxt_s   = 1'b1;
              cam_addr_nxt_s = lookup_addr;
            end else begin
              state_nxt_s      = ST_RESP;
              rsp_valid_nxt_s  = 1'b1;
              rsp_status_nxt_s = RS_NOTFOUND;
            end
          end
          default: begin
            state_nxt_s      = ST_RESP;
            rsp_valid_nxt_s  = 1'b1;
            rsp_status_nxt_s = RS_OK;
          end
        endcase
      end
      ST_WRITE: begin
        // The CAM takes the write on this edge; the bitmap follows it.
        state_nxt_s      = ST_RESP;
        rsp_valid_nxt_s  = 1'b1;
        rsp_status_nxt_s = RS_OK;
        rsp_addr_nxt_s   = cam_addr;
        if (op_r == OP_INSERT) begin
          bitmap_nxt_s[cam_addr] = 1'b1;
        end else begin
          bitmap_nxt_s[cam_addr] = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s     = ST_IDLE;
          req_ready_nxt_s = 1'b1;
        end else begin
          rsp_valid_nxt_s  = 1'b1;
          rsp_status_nxt_s = rsp_status;
          rsp_addr_nxt_s   = rsp_addr;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        sweep_nxt_s = '0;
      end
    endcase
  end

`ifdef CAM_CTRL_STATS_EN
  // Saturating usage counters, sampled while the search result is evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups <= 32'd0;
      stat_hits    <= 32'd0;
      stat_full    <= 32'd0;
    end else if (state_r == ST_EVAL) begin
      if (op_r == OP_LOOKUP && stat_lookups != 32'hFFFF_FFFF) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (op_r == OP_LOOKUP && lookup_hit && stat_hits != 32'hFFFF_FFFF) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (op_r == OP_INSERT && !lookup_hit && occ_count == DEPTH_C &&
          stat_full != 32'hFFFF_FFFF) begin
        stat_full <= stat_full + 32'd1;
      end
    end
  end
`endif

endmodule
